// File: rtl/vrf_writeback_arbiter_if.sv
// Writeback bus between the lane requesters, issue logic and the register file write port.
interface vrf_writeback_arbiter_if #(
   parameter int unsigned VREG_BITS           = 64,
   parameter int unsigned NUMBER_OF_REGISTERS = 32
);
   localparam int unsigned AW = $clog2(NUMBER_OF_REGISTERS);

   logic                           exe_valid;
   logic                           exe_ready;
   logic [AW-1:0]                  exe_dest;
   logic [VREG_BITS-1:0]           exe_data;
   logic                           ld_valid;
   logic                           ld_ready;
   logic [AW-1:0]                  ld_dest;
   logic [VREG_BITS-1:0]           ld_data;
   logic                           reserve_valid;
   logic [AW-1:0]                  reserve_dest;
   logic                           chk_valid;
   logic [AW-1:0]                  chk_addr_1;
   logic [AW-1:0]                  chk_addr_2;
   logic [AW-1:0]                  chk_addr_3;
   logic [AW-1:0]                  chk_dest;
   logic                           hazard;
   logic                           wr_enable;
   logic [AW-1:0]                  wr_destination;
   logic [VREG_BITS-1:0]           wr_data;
   logic [NUMBER_OF_REGISTERS-1:0] pending;

   modport slave (
      input  exe_valid, exe_dest, exe_data, ld_valid, ld_dest, ld_data,
             reserve_valid, reserve_dest, chk_valid, chk_addr_1, chk_addr_2,
             chk_addr_3, chk_dest,
      output exe_ready, ld_ready, hazard, wr_enable, wr_destination, wr_data, pending
   );

   modport master (
      output exe_valid, exe_dest, exe_data, ld_valid, ld_dest, ld_data,
             reserve_valid, reserve_dest, chk_valid, chk_addr_1, chk_addr_2,
             chk_addr_3, chk_dest,
      input  exe_ready, ld_ready, hazard, wr_enable, wr_destination, wr_data, pending
   );
endinterface

// File: rtl/vrf_writeback_arbiter.sv
// Round-robin arbiter for the VRF write port with a per-register pending scoreboard.
// Optional VRF_WB_STATS_EN adds saturating conflict_count / write_count outputs.
module vrf_writeback_arbiter #(
   parameter int unsigned VREG_BITS           = 64,
   parameter int unsigned NUMBER_OF_REGISTERS = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   vrf_writeback_arbiter_if.slave bus
`ifdef VRF_WB_STATS_EN
   ,
   output logic [31:0]           conflict_count,
   output logic [31:0]           write_count
`endif
);
   localparam int unsigned AW = $clog2(NUMBER_OF_REGISTERS);

   typedef enum logic {
      RR_EXE  = 1'b0,
      RR_LOAD = 1'b1
   } rr_e;

   rr_e                           rr_q, rr_d;
   logic                          conflict;
   logic                          exe_grant;
   logic                          ld_grant;

   logic                          wr_en_q, wr_en_d;
   logic [AW-1:0]                 wr_dest_q, wr_dest_d;
   logic [VREG_BITS-1:0]          wr_data_q, wr_data_d;
   logic [NUMBER_OF_REGISTERS-1:0] pending_q, pending_d;

   // Round-robin pointer: only a conflict grant moves it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_q <= RR_LOAD;
      else     rr_q <= rr_d;
   end

   always_comb begin
      rr_d = rr_q;
      if (conflict) rr_d = (rr_q == RR_LOAD) ? RR_EXE : RR_LOAD;
   end

   always_comb begin
      conflict  = bus.exe_valid & bus.ld_valid;
      exe_grant = 1'b0;
      ld_grant  = 1'b0;
      if (conflict) begin
         ld_grant  = (rr_q == RR_LOAD);
         exe_grant = (rr_q == RR_EXE);
      end else begin
         exe_grant = bus.exe_valid;
         ld_grant  = bus.ld_valid;
      end
   end

   // Capture the granted write; address/data hold when idle.
   always_comb begin
      wr_en_d   = exe_grant | ld_grant;
      wr_dest_d = wr_dest_q;
      wr_data_d = wr_data_q;
      if (ld_grant) begin
         wr_dest_d = bus.ld_dest;
         wr_data_d = bus.ld_data;
      end else if (exe_grant) begin
         wr_dest_d = bus.exe_dest;
         wr_data_d = bus.exe_data;
      end
   end

   // Set after clear so a same-edge reservation supersedes the retiring write.
   always_comb begin
      pending_d = pending_q;
      if (wr_en_q)           pending_d[wr_dest_q]        = 1'b0;
      if (bus.reserve_valid) pending_d[bus.reserve_dest] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_en_q   <= 1'b0;
         wr_dest_q <= '0;
         wr_data_q <= '0;
         pending_q <= '0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_dest_q <= wr_dest_d;
         wr_data_q <= wr_data_d;
         pending_q <= pending_d;
      end
   end

   assign bus.exe_ready      = exe_grant;
   assign bus.ld_ready       = ld_grant;
   assign bus.wr_enable      = wr_en_q;
   assign bus.wr_destination = wr_dest_q;
   assign bus.wr_data        = wr_data_q;
   assign bus.pending        = pending_q;
   assign bus.hazard         = bus.chk_valid & (pending_q[bus.chk_addr_1] |
                                                pending_q[bus.chk_addr_2] |
                                                pending_q[bus.chk_addr_3] |
                                                pending_q[bus.chk_dest]);

`ifdef VRF_WB_STATS_EN
   logic [31:0] conflict_cnt_q, conflict_cnt_d;
   logic [31:0] write_cnt_q, write_cnt_d;

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      write_cnt_d    = write_cnt_q;
      if (conflict && !(&conflict_cnt_q)) conflict_cnt_d = conflict_cnt_q + 32'(1);
      if (wr_en_q && !(&write_cnt_q))     write_cnt_d    = write_cnt_q + 32'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         conflict_cnt_q <= '0;
         write_cnt_q    <= '0;
      end else begin
         conflict_cnt_q <= conflict_cnt_d;
         write_cnt_q    <= write_cnt_d;
      end
   end

   assign conflict_count = conflict_cnt_q;
   assign write_count    = write_cnt_q;
`endif
endmodule

// File: tb/tb_vrf_writeback_arbiter.sv
// Self-checking bench: negedge monitor with an arbitration/scoreboard model plus directed scenarios.
module tb_vrf_writeback_arbiter;
   localparam int unsigned VREG_BITS = 64;
   localparam int unsigned NREGS     = 32;
   localparam int unsigned AW        = 5;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vrf_writeback_arbiter_if #(.VREG_BITS(VREG_BITS), .NUMBER_OF_REGISTERS(NREGS)) bus ();

`ifdef VRF_WB_STATS_EN
   logic [31:0] conflict_count;
   logic [31:0] write_count;
`endif

   vrf_writeback_arbiter #(.VREG_BITS(VREG_BITS), .NUMBER_OF_REGISTERS(NREGS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef VRF_WB_STATS_EN
      ,
      .conflict_count (conflict_count),
      .write_count    (write_count)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0]        dest;
      logic [VREG_BITS-1:0] data;
   } wr_t;

   wr_t         exp_q[$];
   logic        m_rr_load = 1'b1;
   logic [31:0] m_pend    = '0;

   // Reference model: expected grants, queued writes and pending vector.
   always @(negedge clk) begin : monitor
      wr_t         w;
      logic [31:0] clr;
      logic [31:0] set;
      logic        ee, le, both, hz;
      if (rst) begin
         exp_q.delete();
         m_rr_load = 1'b1;
         m_pend    = '0;
      end else begin
         clr = '0;
         set = '0;
         check_eq("mon_wr_enable", 64'(bus.wr_enable), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            check_eq("mon_wr_dest", 64'(bus.wr_destination), 64'(w.dest));
            check_eq("mon_wr_data", bus.wr_data, w.data);
            clr[w.dest] = 1'b1;
         end
         check_eq("mon_pending", 64'(bus.pending), 64'(m_pend));
         hz = bus.chk_valid & (m_pend[bus.chk_addr_1] | m_pend[bus.chk_addr_2] |
                               m_pend[bus.chk_addr_3] | m_pend[bus.chk_dest]);
         check_eq("mon_hazard", 64'(bus.hazard), 64'(hz));
         both = bus.exe_valid & bus.ld_valid;
         ee   = bus.exe_valid & (!bus.ld_valid | !m_rr_load);
         le   = bus.ld_valid & (!bus.exe_valid | m_rr_load);
         check_eq("mon_exe_ready", 64'(bus.exe_ready), 64'(ee));
         check_eq("mon_ld_ready", 64'(bus.ld_ready), 64'(le));
         if (le)      exp_q.push_back('{dest: bus.ld_dest, data: bus.ld_data});
         else if (ee) exp_q.push_back('{dest: bus.exe_dest, data: bus.exe_data});
         if (both) m_rr_load = ~m_rr_load;
         if (bus.reserve_valid) set[bus.reserve_dest] = 1'b1;
         m_pend = (m_pend & ~clr) | set;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] ld_g, exe_g;
      logic       ev, lv;
      bus.exe_valid = 0; bus.exe_dest = '0; bus.exe_data = '0;
      bus.ld_valid = 0;  bus.ld_dest = '0;  bus.ld_data = '0;
      bus.reserve_valid = 0; bus.reserve_dest = '0;
      bus.chk_valid = 0; bus.chk_addr_1 = '0; bus.chk_addr_2 = '0;
      bus.chk_addr_3 = '0; bus.chk_dest = '0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset then idle
      bus.chk_valid = 1'b1;
      #1;
      check_eq("rst_wr_enable", 64'(bus.wr_enable), 64'd0);
      check_eq("rst_pending", 64'(bus.pending), 64'd0);
      check_eq("rst_hazard", 64'(bus.hazard), 64'd0);
      cyc();
      bus.chk_valid = 1'b0;

      // Single execute write
      bus.exe_valid = 1'b1; bus.exe_dest = 5'd5; bus.exe_data = 64'hA5A5;
      #1 check_eq("exe_ready_same_cycle", 64'(bus.exe_ready), 64'd1);
      cyc();
      bus.exe_valid = 1'b0;
      #1;
      check_eq("exe_wr_enable", 64'(bus.wr_enable), 64'd1);
      check_eq("exe_wr_dest", 64'(bus.wr_destination), 64'd5);
      check_eq("exe_wr_data", bus.wr_data, 64'hA5A5);
      cyc();
      check_eq("exe_wr_enable_off", 64'(bus.wr_enable), 64'd0);

      // Alternating requesters, starting from a conflict (rr = LOAD)
      ev = 1'b1; lv = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.exe_valid = ev; bus.exe_dest = 5'd1; bus.exe_data = 64'h100 + 64'(i);
         bus.ld_valid  = lv; bus.ld_dest  = 5'd2; bus.ld_data  = 64'h200 + 64'(i);
         #1;
         ld_g[i]  = bus.ld_ready;
         exe_g[i] = bus.exe_ready;
         cyc();
         ev = !exe_g[i];
         lv = !ld_g[i];
      end
      check_eq("alt_ld_grants", 64'(ld_g), 64'(4'b0101));
      check_eq("alt_exe_grants", 64'(exe_g), 64'(4'b1010));

      // Two back-to-back conflicts: rr now favours exe
      for (int i = 0; i < 2; i++) begin
         bus.exe_valid = 1'b1; bus.exe_data = 64'h300 + 64'(i);
         bus.ld_valid  = 1'b1; bus.ld_data  = 64'h400 + 64'(i);
         #1;
         ld_g[i]  = bus.ld_ready;
         exe_g[i] = bus.exe_ready;
         cyc();
      end
      check_eq("conf_ld_grants", 64'(ld_g[1:0]), 64'(2'b10));
      check_eq("conf_exe_grants", 64'(exe_g[1:0]), 64'(2'b01));
      bus.exe_valid = 1'b0; bus.ld_valid = 1'b0;
      cyc(); cyc();

      // Reserve 7, query it, then retire it with a load write
      bus.reserve_valid = 1'b1; bus.reserve_dest = 5'd7;
      cyc();
      bus.reserve_valid = 1'b0;
      bus.chk_valid = 1'b1; bus.chk_addr_2 = 5'd7;
      #1 check_eq("rsv7_hazard", 64'(bus.hazard), 64'd1);
      bus.ld_valid = 1'b1; bus.ld_dest = 5'd7; bus.ld_data = 64'h77;
      cyc();
      bus.ld_valid = 1'b0;
      #1;
      check_eq("wr7_enable", 64'(bus.wr_enable), 64'd1);
      check_eq("wr7_hazard_no_bypass", 64'(bus.hazard), 64'd1);
      cyc();
      check_eq("wr7_hazard_cleared", 64'(bus.hazard), 64'd0);
      check_eq("wr7_pending_cleared", 64'(bus.pending[7]), 64'd0);
      bus.chk_valid = 1'b0; bus.chk_addr_2 = '0;

      // Reserve and retire register 3 on the same edge: set wins
      bus.reserve_valid = 1'b1; bus.reserve_dest = 5'd3;
      cyc();
      bus.reserve_valid = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_dest = 5'd3; bus.ld_data = 64'h33;
      cyc();
      bus.ld_valid = 1'b0;
      bus.reserve_valid = 1'b1; bus.reserve_dest = 5'd3;
      cyc();
      bus.reserve_valid = 1'b0;
      check_eq("same_edge_pending3", 64'(bus.pending[3]), 64'd1);
      bus.ld_valid = 1'b1; bus.ld_dest = 5'd3; bus.ld_data = 64'h34;
      cyc();
      bus.ld_valid = 1'b0;
      cyc();
      check_eq("pending3_retired", 64'(bus.pending), 64'd0);

      // Asynchronous reset while a write is in flight
      bus.reserve_valid = 1'b1; bus.reserve_dest = 5'd0;
      cyc();
      bus.reserve_dest = 5'd7;
      cyc();
      bus.reserve_valid = 1'b0;
      bus.exe_valid = 1'b1; bus.exe_dest = 5'd9; bus.exe_data = 64'h99;
      cyc();
      bus.exe_valid = 1'b0;
      #1;
      check_eq("pre_rst_wr_enable", 64'(bus.wr_enable), 64'd1);
      check_eq("pre_rst_pending", 64'(bus.pending), 64'h81);
      rst = 1'b1;
      #1;
      check_eq("async_rst_wr_enable", 64'(bus.wr_enable), 64'd0);
      check_eq("async_rst_pending", 64'(bus.pending), 64'd0);
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      check_eq("post_rst_wr_enable", 64'(bus.wr_enable), 64'd0);
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vrf_writeback_arbiter.md
Name: vrf_writeback_arbiter

Overview:
- Shares the vector register file's single write port between two writeback requesters: execute-unit results and load-unit returns.
- Holds a per-register pending scoreboard. Issue logic reserves a destination; the scoreboard releases it when the write reaches the register file.
- Gives issue a combinational hazard check for up to three sources plus one destination.
- Sits between the lane writeback paths and the register file write_enable/destination/write_data inputs.

Parameters:
- VREG_BITS, 64, width of one vector register slice in the lane.
- NUMBER_OF_REGISTERS, 32, number of architectural vector registers; AW = $clog2(NUMBER_OF_REGISTERS).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- exe_valid  in  1  execute writeback request.
- exe_ready  out  1  execute request granted this cycle.
- exe_dest  in  AW  execute destination register.
- exe_data  in  VREG_BITS  execute result.
- ld_valid  in  1  load writeback request.
- ld_ready  out  1  load request granted this cycle.
- ld_dest  in  AW  load destination register.
- ld_data  in  VREG_BITS  load data.
- reserve_valid  in  1  issue marks reserve_dest pending.
- reserve_dest  in  AW  register to reserve.
- chk_valid  in  1  hazard query enable.
- chk_addr_1 / chk_addr_2 / chk_addr_3  in  AW  source registers to check.
- chk_dest  in  AW  destination register to check.
- hazard  out  1  query hits a pending register.
- wr_enable  out  1  register file write strobe.
- wr_destination  out  AW  register file write address.
- wr_data  out  VREG_BITS  register file write data.
- pending  out  NUMBER_OF_REGISTERS  scoreboard bit vector.

Behaviour:
- Reset (async, active-high):
  - wr_enable=0, wr_destination=0, wr_data=0.
  - pending=all 0.
  - Round-robin pointer rr=LOAD, meaning load wins the next conflict.
- Arbitration (combinational):
  - Only exe valid -> exe granted.
  - Only ld valid -> ld granted.
  - Both valid -> side selected by rr; rr then flips to the other side at the clock edge.
  - rr changes only on a conflict grant.
  - exe_ready/ld_ready are the grant signals: at most one is high, and never without its valid.
- Requester rules: hold valid, dest and data stable until ready. The arbiter applies no backpressure from the register file; one write is accepted every cycle.
- Output stage:
  - Handshake at edge N -> wr_enable=1 with the captured dest/data during cycle N+1 (latency 1). The register file commits at edge N+1.
  - No handshake -> wr_enable=0; wr_destination/wr_data hold their last values.
- Scoreboard, at each edge:
  - pending[reserve_dest] is set if reserve_valid.
  - pending[wr_destination] is cleared if wr_enable.
  - Same register set and cleared in one edge -> set wins, because a new writer supersedes the old one.
  - Reserving an already-pending register leaves it set. Issue must use hazard on chk_dest to avoid this (single bit, no counting).
  - A write to a non-pending register is legal and leaves pending unchanged.
- hazard = chk_valid & (pending[chk_addr_1] | pending[chk_addr_2] | pending[chk_addr_3] | pending[chk_dest]).
  - Purely combinational from current pending.
  - No bypass of a same-edge clear.
- Same dest from both requesters in one cycle: serialised in rr order; the last granted data ends up in the register.
- Reset mid-operation: the captured write is dropped (wr_enable forced 0) and all reservations are lost; upstream is flushed by the same reset.

Optional Feature:
- Macro: VRF_WB_STATS_EN.
- Defined -> adds outputs:
  - conflict_count (32 bit): increments each cycle both exe_valid and ld_valid are high.
  - write_count (32 bit): increments each cycle wr_enable is high.
  - Both reset to 0 and saturate at all-ones.
- Undefined -> ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then idle -> wr_enable=0, pending=0, hazard=0 with chk_valid=1 and all addresses=0.
- exe_valid=1, exe_dest=5, exe_data=0xA5A5 for one cycle -> exe_ready=1 same cycle; next cycle wr_enable=1, wr_destination=5, wr_data=0xA5A5; then wr_enable=0.
- Both valid for 4 cycles (exe_dest=1, ld_dest=2), each requester dropping valid after its grant and reasserting it the next cycle -> grants alternate ld, exe, ld, exe; writes appear one cycle later in the same order.
- reserve_valid with reserve_dest=7, then chk_addr_2=7 with chk_valid=1 -> hazard=1; ld write to 7 -> pending[7] clears at the write edge and hazard=0 the following cycle.
- reserve_dest=3 at the same edge a wr_enable write to 3 commits -> pending[3] remains 1.
- Assert rst while wr_enable=1 and pending=0x0000_0081 -> wr_enable=0 and pending=0 immediately, without waiting for a clock edge.
